mux2_arbiter: RTL and testbench
===============================

# mux2_arbiter

Round-robin arbiter and sequencer for the shared 2-to-1 data multiplexer: two requesters compete for one output channel, and the block grants one at a time and drives the mux select. Under contention, a grant is held for a bounded burst. Sits directly in front of the 2:1 mux datapath; `y`/`y_valid` feed the downstream consumer.

## Interface
- `WIDTH`, default 8: data width of each requester and of `y`.
- `HOLD_MAX`, default 4: maximum consecutive granted cycles under contention (≥1). Only used when the timeout feature is compiled in.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  2  `req[i]` = requester i wants the channel; held until done.
- `d0`  in  WIDTH  data from requester 0.
- `d1`  in  WIDTH  data from requester 1.
- `gnt`  out  2  one-hot grant, or 00 when idle; registered.
- `s`  out  1  mux select. 0 selects `d0`, 1 selects `d1`. Registered; equals `gnt[1]`.
- `y`  out  WIDTH  muxed data; combinational: `s ? d1 : d0`.
- `y_valid`  out  1  combinational: `|(gnt & req)`.

## Operation
- **States:** `IDLE`, `G0`, `G1`. `gnt`/`s` are decoded from the state: `IDLE`→00/0, `G0`→01/0, `G1`→10/1.
- **Registers:**
  - state.
  - `last` (most recently granted requester).
  - `cnt`, `$clog2(HOLD_MAX+1)` bits: cycles held in the current grant.
- **Reset values:**
  - state `IDLE`, `gnt`=00, `s`=0, `y_valid`=0. `y` follows `d0`.
  - `last`=1, so requester 0 wins the first tie. `cnt`=0.
- **`IDLE` transitions:**
  - `req`=00: stay.
  - `req`=01: go to `G0`.
  - `req`=10: go to `G1`.
  - `req`=11: go to `G(~last)`.
- **`Gi` transitions** (other requester = j):
  - `req[i]`=0 and `req[j]`=1: go to `Gj`. No idle bubble.
  - `req[i]`=0 and `req[j]`=0: go to `IDLE`.
  - `req[i]`=1: stay in `Gi`, unless the timeout preemption under Configuration applies.
- Every entry into a grant state loads `last`=i and `cnt`=0. Staying increments `cnt`, saturating at `HOLD_MAX-1`.
- **Simultaneous events:** when the holder drops `req` and the other requester asserts in the same cycle, the grant switches directly. Round-robin applies only to ties from `IDLE` and to timeout preemption.
- Grant is never one-hot-violated; `gnt`=11 is unreachable.

## Timing
- **Grant latency:** `req[i]` rises before edge k in `IDLE` → `gnt[i]`=1 and `s` valid after edge k. `y_valid` rises in the same cycle as `gnt`.
- **Release:** `req[i]` drops before edge k.
  - Between that `req` drop and edge k, `gnt[i]` is still 1 but `y_valid`=0, because `y_valid` is combinational on `req`.
  - After edge k, `gnt` moves to `j` or 00.
- **Switch:** `s` changes on the same edge as `gnt`. `y` changes combinationally after that edge.
- **Reset mid-grant:** `gnt`, `s`, and `y_valid` go to 0 immediately on `rst` assertion, without waiting for a clock. The first grant after `rst` deasserts follows the reset-state rules.

## Configuration
- `MUX2_ARB_TIMEOUT_EN` defined:
  - In `Gi` with `req[i]`=1, `req[j]`=1 and `cnt`=`HOLD_MAX-1`: go to `Gj`.
  - So a holder under contention gets at most `HOLD_MAX` consecutive cycles.
  - If `req[j]`=0, stay in `Gi` with `cnt` saturated; preemption happens on the first cycle `req[j]` is seen.
  - `HOLD_MAX`=1 alternates grants every cycle under contention.
- `MUX2_ARB_TIMEOUT_EN` undefined:
  - The holder keeps the grant until it drops `req`. `HOLD_MAX` is ignored.
  - The `cnt` register may be omitted.

## Test plan
- **Reset:** assert `rst` with `req`=11 → `gnt`=00, `s`=0, `y_valid`=0, `y`=`d0`. Release `rst` → next edge `gnt`=01.
- **Single requester:** `d1`=8'hA5, `req`=10 for 3 cycles then 00.
  - `gnt`=10, `s`=1, `y`=8'hA5, `y_valid`=1 for 3 cycles.
  - Then `gnt`=00.
- **Handoff without bubble:** in `G0`, drop `req[0]` and raise `req[1]` in the same cycle → next edge `gnt`=10, no `IDLE` cycle.
- **Tie rotation:** from `IDLE` with `last`=0, `req`=11 → `gnt`=10.
  - Drop `req[1]` → `gnt`=01.
- **Timeout (macro defined, `HOLD_MAX`=4):** hold `req`=11 → `gnt` sequence 01×4, 10×4, 01×4.
  - Without the macro, the same stimulus gives `gnt`=01 indefinitely.
- **Async reset mid-grant:** assert `rst` between edges while `gnt`=10 → `gnt`=00 and `s`=0 before the next edge.

Source files
------------

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin grant sequencer that drives the select of a shared 2:1 data mux.
// Optional burst-limit preemption under contention is compiled in with MUX2_ARB_TIMEOUT_EN.
`default_nettype none

module mux2_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [1:0]       gnt,
    output logic             s,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_last;
    logic [1:0] r_gnt;
    logic       r_s;

    if (HOLD_MAX < 1) begin : g_bad_hold_max
        $error("mux2_arbiter: HOLD_MAX must be at least 1");
    end

`ifdef MUX2_ARB_TIMEOUT_EN
    localparam int unsigned      CNT_W   = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    assign w_expired = (r_cnt == CNT_MAX);
`endif

    // A holder that drops req hands over directly to a waiting peer; round-robin only breaks ties.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                unique case (req)
                    2'b01:   w_next = G0;
                    2'b10:   w_next = G1;
                    2'b11:   w_next = r_last ? G0 : G1;
                    default: w_next = IDLE;
                endcase
            end
            G0: begin
                if (!req[0]) begin
                    w_next = req[1] ? G1 : IDLE;
                end
`ifdef MUX2_ARB_TIMEOUT_EN
                else if (req[1] && w_expired) begin
                    w_next = G1;
                end
`endif
            end
            G1: begin
                if (!req[1]) begin
                    w_next = req[0] ? G0 : IDLE;
                end
`ifdef MUX2_ARB_TIMEOUT_EN
                else if (req[0] && w_expired) begin
                    w_next = G0;
                end
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_s     <= 1'b0;
            r_last  <= 1'b1;
`ifdef MUX2_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_next;

            unique case (w_next)
                G0: begin
                    r_gnt <= 2'b01;
                    r_s   <= 1'b0;
                end
                G1: begin
                    r_gnt <= 2'b10;
                    r_s   <= 1'b1;
                end
                default: begin
                    r_gnt <= 2'b00;
                    r_s   <= 1'b0;
                end
            endcase

            if ((w_next != IDLE) && (w_next != r_state)) begin
                r_last <= (w_next == G1);
            end

`ifdef MUX2_ARB_TIMEOUT_EN
            // Count restarts on every grant entry and saturates while the holder keeps the channel.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((w_next != IDLE) && !w_expired) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
`endif
        end
    end

    assign gnt     = r_gnt;
    assign s       = r_s;
    assign y       = r_s ? d1 : d0;
    assign y_valid = |(r_gnt & req);

endmodule

`default_nettype wire

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: table-driven vectors through a scoreboard queue plus reset/timeout sequences.
module tb_mux2_arbiter;

    localparam int WIDTH    = 8;
    localparam int HOLD_MAX = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [WIDTH-1:0] d0  = '0;
    logic [WIDTH-1:0] d1  = '0;
    logic [1:0]       gnt;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    mux2_arbiter #(
        .WIDTH    (WIDTH),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d0      (d0),
        .d1      (d1),
        .gnt     (gnt),
        .s       (s),
        .y       (y),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       req;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        logic [1:0]       gnt;
        logic             s;
        logic [WIDTH-1:0] y;
        logic             yv;
    } vec_t;

    typedef struct {
        logic [1:0]       gnt;
        logic             s;
        logic [WIDTH-1:0] y;
        logic             yv;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] g, input logic sv, input logic [WIDTH-1:0] yy, input logic v);
        exp_t e;
        e.gnt = g;
        e.s   = sv;
        e.y   = yy;
        e.yv  = v;
        sb.push_back(e);
    endtask

    task automatic edge_and_check(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got gnt %0h expected an entry", nm, gnt);
        end else begin
            e = sb.pop_front();
            chk({nm, ".gnt"}, 32'(gnt), 32'(e.gnt));
            chk({nm, ".s"}, 32'(s), 32'(e.s));
            chk({nm, ".y"}, 32'(y), 32'(e.y));
            chk({nm, ".y_valid"}, 32'(y_valid), 32'(e.yv));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[16];
        logic [1:0] prev_gnt;
        logic [1:0] tgnt;

        vecs[0]  = '{2'b11, 8'h3C, 8'hA5, 2'b01, 1'b0, 8'h3C, 1'b1};
        vecs[1]  = '{2'b01, 8'h11, 8'h22, 2'b01, 1'b0, 8'h11, 1'b1};
        vecs[2]  = '{2'b10, 8'h33, 8'h44, 2'b10, 1'b1, 8'h44, 1'b1};
        vecs[3]  = '{2'b10, 8'h55, 8'hA5, 2'b10, 1'b1, 8'hA5, 1'b1};
        vecs[4]  = '{2'b10, 8'h55, 8'hA5, 2'b10, 1'b1, 8'hA5, 1'b1};
        vecs[5]  = '{2'b00, 8'h66, 8'h77, 2'b00, 1'b0, 8'h66, 1'b0};
        vecs[6]  = '{2'b00, 8'h66, 8'h77, 2'b00, 1'b0, 8'h66, 1'b0};
        vecs[7]  = '{2'b10, 8'h00, 8'hA5, 2'b10, 1'b1, 8'hA5, 1'b1};
        vecs[8]  = '{2'b10, 8'h00, 8'hA5, 2'b10, 1'b1, 8'hA5, 1'b1};
        vecs[9]  = '{2'b10, 8'h00, 8'hA5, 2'b10, 1'b1, 8'hA5, 1'b1};
        vecs[10] = '{2'b00, 8'h5A, 8'hA5, 2'b00, 1'b0, 8'h5A, 1'b0};
        vecs[11] = '{2'b01, 8'h81, 8'h18, 2'b01, 1'b0, 8'h81, 1'b1};
        vecs[12] = '{2'b00, 8'h81, 8'h18, 2'b00, 1'b0, 8'h81, 1'b0};
        vecs[13] = '{2'b11, 8'hC3, 8'h3C, 2'b10, 1'b1, 8'h3C, 1'b1};
        vecs[14] = '{2'b01, 8'hC3, 8'h3C, 2'b01, 1'b0, 8'hC3, 1'b1};
        vecs[15] = '{2'b00, 8'hF0, 8'h0F, 2'b00, 1'b0, 8'hF0, 1'b0};

        // Reset with both requesters active.
        #1 rst = 1'b1;
        req = 2'b11;
        d0  = 8'h3C;
        d1  = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.gnt", 32'(gnt), 32'h0);
        chk("reset.s", 32'(s), 32'h0);
        chk("reset.y_valid", 32'(y_valid), 32'h0);
        chk("reset.y", 32'(y), 32'h3C);

        prev_gnt = 2'b00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst = 1'b0;
            req = vecs[i].req;
            d0  = vecs[i].d0;
            d1  = vecs[i].d1;
            #1;
            // Before the edge the grant is the old one while y_valid already follows req.
            chk($sformatf("vec%0d.pre_gnt", i), 32'(gnt), 32'(prev_gnt));
            chk($sformatf("vec%0d.pre_y_valid", i), 32'(y_valid), 32'(|(prev_gnt & vecs[i].req)));
            push_exp(vecs[i].gnt, vecs[i].s, vecs[i].y, vecs[i].yv);
            edge_and_check($sformatf("vec%0d", i));
            prev_gnt = vecs[i].gnt;
        end

        // Reset restores last=1, then sustained contention.
        @(negedge clk);
        rst = 1'b1;
        req = 2'b11;
        d0  = 8'h12;
        d1  = 8'h34;
        #1;
        chk("rst2.gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
`ifdef MUX2_ARB_TIMEOUT_EN
            tgnt = (((c / HOLD_MAX) % 2) == 0) ? 2'b01 : 2'b10;
`else
            tgnt = 2'b01;
`endif
            push_exp(tgnt, tgnt[1], tgnt[1] ? 8'h34 : 8'h12, 1'b1);
            edge_and_check($sformatf("contend%0d", c));
        end

        // Asynchronous reset while requester 1 holds the grant.
        @(negedge clk);
        req = 2'b10;
        push_exp(2'b10, 1'b1, 8'h34, 1'b1);
        edge_and_check("pre_async");
        #2 rst = 1'b1;
        #1;
        chk("async.gnt", 32'(gnt), 32'h0);
        chk("async.s", 32'(s), 32'h0);
        chk("async.y_valid", 32'(y_valid), 32'h0);
        chk("async.y", 32'(y), 32'h12);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b11;
        push_exp(2'b01, 1'b0, 8'h12, 1'b1);
        edge_and_check("post_async_tie");

        @(negedge clk);
        req = 2'b00;
        push_exp(2'b00, 1'b0, 8'h12, 1'b0);
        edge_and_check("final_idle");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
